// File: rtl/arith_accum_unit.sv
// Handshaked add/sub/accumulate/clear unit with a single-entry registered result.
// Optional saturation of ADD/SUB/ACC results is enabled by defining ARITH_ACCUM_SAT_EN.
module arith_accum_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic [CNT_W-1:0] op_count
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; in_valid may be raised freely, and in_ready never depends on in_valid.
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ACC = 2'b10,
    OP_CLR = 2'b11
  } op_e;

  localparam int MSB = WIDTH - 1;

  op_e              op_s;
  logic             run_q, run_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             xfer;
  logic             drain;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic [WIDTH-1:0] res_raw;
  logic [WIDTH-1:0] res_val;
  logic             res_c;
  logic             res_ov;

  assign op_s = op_e'(op);

  // run_q keeps in_ready low for the first cycle after reset release.
  assign in_ready = ena & run_q & (~out_valid_q | out_ready);
  assign xfer     = in_valid & in_ready;
  assign drain    = out_valid_q & out_ready;

  always_comb begin
    op_a = a;
    op_b = b;
    if (op_s == OP_ACC) begin
      op_a = acc_q;
      op_b = a;
    end
  end

  assign sum_w  = {1'b0, op_a} + {1'b0, op_b};
  assign diff_w = {1'b0, a} - {1'b0, b};

  always_comb begin
    res_raw = '0;
    res_c   = 1'b0;
    res_ov  = 1'b0;
    unique case (op_s)
      OP_ADD, OP_ACC: begin
        res_raw = sum_w[WIDTH-1:0];
        res_c   = sum_w[WIDTH];
        res_ov  = (op_a[MSB] == op_b[MSB]) && (res_raw[MSB] != op_a[MSB]);
      end
      OP_SUB: begin
        res_raw = diff_w[WIDTH-1:0];
        res_c   = diff_w[WIDTH];
        res_ov  = (a[MSB] != b[MSB]) && (res_raw[MSB] != a[MSB]);
      end
      default: begin
        res_raw = '0;
      end
    endcase
  end

  // Flags always describe the raw operation; only the stored value is clamped.
  always_comb begin
    res_val = res_raw;
`ifdef ARITH_ACCUM_SAT_EN
    if (res_c) begin
      if (op_s == OP_SUB) res_val = '0;
      else                res_val = '1;
    end
`endif
  end

  always_comb begin
    run_d       = 1'b1;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    carry_d     = carry_q;
    overflow_d  = overflow_q;
    op_count_d  = op_count_q;
    acc_d       = acc_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      result_d    = res_val;
      carry_d     = res_c;
      overflow_d  = res_ov;
      op_count_d  = op_count_q + 1'b1;
      if (op_s == OP_ACC)      acc_d = res_val;
      else if (op_s == OP_CLR) acc_d = '0;
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q       <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      op_count_q  <= '0;
      acc_q       <= '0;
    end else begin
      run_q       <= run_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
      op_count_q  <= op_count_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_arith_accum_unit.sv
// Directed, table-driven bench for arith_accum_unit (WIDTH=8, CNT_W=8, wrapping build).
module tb_arith_accum_unit;

  localparam int WIDTH = 8;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             ena;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;
  logic [CNT_W-1:0] op_count;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp_result;
    logic             exp_carry;
    logic             exp_ov;
  } vec_t;

  vec_t vecs[$];
  logic [WIDTH-1:0] exp_q[$];

  arith_accum_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .overflow  (overflow),
    .op_count  (op_count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] o, input logic [7:0] va, input logic [7:0] vb,
                              input logic [7:0] r, input logic c, input logic v);
    vec_t t;
    t.op = o; t.a = va; t.b = vb; t.exp_result = r; t.exp_carry = c; t.exp_ov = v;
    return t;
  endfunction

  // Driver: present one operation for a single transfer edge.
  task automatic apply(input logic [1:0] o, input logic [7:0] va, input logic [7:0] vb);
    @(negedge clk);
    op = o; a = va; b = vb; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    logic [CNT_W-1:0] cnt0;
    logic [WIDTH-1:0] held;
    tests_run    = 0;
    tests_failed = 0;
    rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op = 2'b00; a = '0; b = '0;

    // ADD, SUB, ACC, CLR vectors; acc state carries down the table.
    vecs.push_back(mk(2'b11, 8'h55, 8'h11, 8'h00, 1'b0, 1'b0));
    vecs.push_back(mk(2'b00, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0));
    vecs.push_back(mk(2'b01, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0));
    vecs.push_back(mk(2'b01, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1));
    vecs.push_back(mk(2'b10, 8'h30, 8'h99, 8'h30, 1'b0, 1'b0));
    vecs.push_back(mk(2'b10, 8'h50, 8'h00, 8'h80, 1'b0, 1'b1));
    vecs.push_back(mk(2'b00, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0));
    vecs.push_back(mk(2'b10, 8'h01, 8'h00, 8'h81, 1'b0, 1'b0));
    vecs.push_back(mk(2'b00, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1));
    vecs.push_back(mk(2'b00, 8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0));
    vecs.push_back(mk(2'b01, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0));
    vecs.push_back(mk(2'b10, 8'h80, 8'h00, 8'h01, 1'b1, 1'b1));
    vecs.push_back(mk(2'b01, 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1));
    vecs.push_back(mk(2'b11, 8'hAA, 8'hBB, 8'h00, 1'b0, 1'b0));
    vecs.push_back(mk(2'b10, 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0));

    // Power-on reset values and the one-cycle in_ready hold-off after release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_op_count", op_count, 0);
    check("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    #1 check("in_ready_before_edge", in_ready, 0);
    @(posedge clk);
    #1 check("in_ready_after_release", in_ready, 1);

    // Table: one transfer per vector, result checked just after the edge.
    foreach (vecs[i]) begin
      apply(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_valid", i), out_valid, 1);
      check($sformatf("vec%0d_result", i), result, vecs[i].exp_result);
      check($sformatf("vec%0d_carry", i), carry, vecs[i].exp_carry);
      check($sformatf("vec%0d_overflow", i), overflow, vecs[i].exp_ov);
    end
    check("count_after_table", op_count, 8'd15);
    @(posedge clk);
    #1 check("drained_valid", out_valid, 0);

    // Backpressure: held result, one count, then simultaneous drain + accept.
    cnt0 = op_count;
    @(negedge clk);
    out_ready = 1'b0; op = 2'b00; a = 8'h03; b = 8'h04; in_valid = 1'b1;
    @(posedge clk);
    #1 a = 8'h10; b = 8'h20;
    exp_q.push_back(8'h07);
    exp_q.push_back(8'h30);
    held = exp_q.pop_front();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp%0d_in_ready", c), in_ready, 0);
      check($sformatf("bp%0d_result", c), result, held);
      check($sformatf("bp%0d_valid", c), out_valid, 1);
      check($sformatf("bp%0d_count", c), op_count, cnt0 + 8'd1);
    end
    out_ready = 1'b1;
    #1 check("bp_release_in_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("bp_pass_valid", out_valid, 1);
    check("bp_pass_result", result, exp_q.pop_front());
    check("bp_pass_count", op_count, cnt0 + 8'd2);
    @(posedge clk);
    #1 check("bp_drain_valid", out_valid, 0);

    // 256 back-to-back operations wrap op_count to its start value.
    cnt0 = op_count;
    @(negedge clk);
    op = 2'b00; a = 8'h01; b = 8'h02; in_valid = 1'b1;
    repeat (128) @(posedge clk);
    #1 check("wrap_mid_count", op_count, cnt0 + 8'd128);
    check("wrap_mid_in_ready", in_ready, 1);
    repeat (128) @(posedge clk);
    #1 in_valid = 1'b0;
    check("wrap_count", op_count, cnt0);
    check("wrap_result", result, 8'h03);
    @(posedge clk);

    // Enable low blocks transfers; a held result can still drain.
    cnt0 = op_count;
    @(negedge clk);
    ena = 1'b0; in_valid = 1'b1;
    #1 check("ena_low_in_ready", in_ready, 0);
    repeat (3) @(posedge clk);
    #1 check("ena_low_count", op_count, cnt0);
    check("ena_low_valid", out_valid, 0);
    @(negedge clk);
    ena = 1'b1; out_ready = 1'b0; op = 2'b01; a = 8'h09; b = 8'h04;
    @(posedge clk);
    #1 ena = 1'b0; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("ena_fall_hold_valid", out_valid, 1);
    check("ena_fall_hold_result", result, 8'h05);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 check("ena_fall_drain", out_valid, 0);
    check("ena_fall_count", op_count, cnt0 + 8'd1);

    // Asynchronous reset with a pending result discards it.
    @(negedge clk);
    ena = 1'b1; out_ready = 1'b0; op = 2'b00; a = 8'h11; b = 8'h22; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("pre_reset_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1 check("midrst_valid", out_valid, 0);
    check("midrst_result", result, 0);
    check("midrst_carry", carry, 0);
    check("midrst_overflow", overflow, 0);
    check("midrst_count", op_count, 0);
    check("midrst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 check("post_rst_in_ready", in_ready, 1);
    check("post_rst_valid", out_valid, 0);
    // acc was cleared by reset: ACC 0x05 returns 0x05.
    apply(2'b10, 8'h05, 8'h00);
    check("post_rst_acc", result, 8'h05);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
